// File: rtl/fifo_pkg.sv
// Shared constants and counter-width helpers for the FIFO read-side adaptors.
package fifo_pkg;

  localparam int unsigned FIFO_BURST_LEN_DEF = 16;
  localparam int unsigned FIFO_TIMEOUT_DEF   = 64;

  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_HELD  = 1'b1
  } hold_state_e;

  // Beat counter only needs to reach BURST_LEN-1.
  function automatic int unsigned beat_cnt_w(input int unsigned burst_len);
    return (burst_len < 2) ? 1 : $clog2(burst_len);
  endfunction

  // Idle counter must be able to hold TIMEOUT itself.
  function automatic int unsigned idle_cnt_w(input int unsigned timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/fifo_burst_reader_m_if.sv
// FIFO read port plus downstream valid/ready stream of the burst reader.
interface fifo_burst_reader_m_if #(
  parameter type DATA_ITEM_TYPE = logic
) ();

  DATA_ITEM_TYPE head;
  logic          empty;
  logic          rd_rst_busy;
  logic          pop;
  DATA_ITEM_TYPE m_data;
  logic          m_valid;
  logic          m_last;
  logic          m_ready;

  modport master (
    input  head, empty, rd_rst_busy, m_ready,
    output pop, m_data, m_valid, m_last
  );

  modport slave (
    output head, empty, rd_rst_busy, m_ready,
    input  pop, m_data, m_valid, m_last
  );

endinterface

// File: rtl/fifo_burst_reader_m_stream_reg.sv
// One-entry valid/ready register slice; o_free tells the producer a load is accepted.
module stream_reg_m #(
  parameter type DATA_ITEM_TYPE = logic
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  DATA_ITEM_TYPE i_data,
  input  logic          i_last,
  input  logic          i_ready,
  output logic          o_free,
  output logic          o_valid,
  output DATA_ITEM_TYPE o_data,
  output logic          o_last
);

  assign o_free = !o_valid || i_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      o_data  <= '0;
    end else if (i_load) begin
      o_valid <= 1'b1;
      o_last  <= i_last;
      o_data  <= i_data;
    end else if (o_free) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_burst_reader_m.sv
// FWFT FIFO consumer: one-word hold stage feeding a registered stream with burst framing.
module fifo_burst_reader_m
  import fifo_pkg::*;
#(
  parameter type         DATA_ITEM_TYPE = logic,
  parameter int unsigned BURST_LEN      = FIFO_BURST_LEN_DEF,
  parameter int unsigned TIMEOUT        = FIFO_TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  output logic                  busy,
  fifo_burst_reader_m_if.master bus
);

  localparam int unsigned     BW     = beat_cnt_w(BURST_LEN);
  localparam int unsigned     IW     = idle_cnt_w(TIMEOUT);
  localparam logic [BW-1:0]   LP_CAP = BW'(BURST_LEN - 1);
  localparam logic [IW-1:0]   LP_TMO = IW'(TIMEOUT);

  hold_state_e   r_hold_state;
  DATA_ITEM_TYPE r_hold_data;
  logic [BW-1:0] r_beat_cnt;
  logic [IW-1:0] r_idle_cnt;

  logic w_hold_valid;
  logic w_avail;
  logic w_out_free;
  logic w_idle_sat;
  logic w_tmo;
  logic w_cap;
  logic w_xfer;
  logic w_pop;
  logic w_last_next;
  logic w_m_valid;

  assign w_hold_valid = (r_hold_state == HOLD_HELD);
  assign w_avail      = !bus.empty && !bus.rd_rst_busy;
  assign w_idle_sat   = (r_idle_cnt == LP_TMO);
  assign w_tmo        = flush || w_idle_sat;
  assign w_cap        = (r_beat_cnt == LP_CAP);

  // A held word only leaves once its successor is known, or the burst must close anyway.
  assign w_xfer      = w_hold_valid && w_out_free && (w_avail || w_cap || w_tmo);
  assign w_pop       = w_avail && (!w_hold_valid || w_xfer);
  assign w_last_next = w_cap || (!w_avail && w_tmo);

  assign bus.pop = w_pop;
  assign busy    = w_hold_valid || w_m_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_state <= HOLD_EMPTY;
      r_hold_data  <= '0;
      r_beat_cnt   <= '0;
      r_idle_cnt   <= '0;
    end else begin
      case (r_hold_state)
        HOLD_EMPTY: if (w_pop)            r_hold_state <= HOLD_HELD;
        HOLD_HELD:  if (w_xfer && !w_pop) r_hold_state <= HOLD_EMPTY;
        default:                          r_hold_state <= HOLD_EMPTY;
      endcase

      if (w_pop) begin
        r_hold_data <= bus.head;
      end

      if (w_xfer) begin
        r_beat_cnt <= w_last_next ? '0 : r_beat_cnt + 1'b1;
      end

      if (!w_hold_valid || w_pop) begin
        r_idle_cnt <= '0;
      end else if (!w_avail && !w_idle_sat) begin
        r_idle_cnt <= r_idle_cnt + 1'b1;
      end
    end
  end

  stream_reg_m #(
    .DATA_ITEM_TYPE(DATA_ITEM_TYPE)
  ) u_out (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_xfer),
    .i_data (r_hold_data),
    .i_last (w_last_next),
    .i_ready(bus.m_ready),
    .o_free (w_out_free),
    .o_valid(w_m_valid),
    .o_data (bus.m_data),
    .o_last (bus.m_last)
  );

  assign bus.m_valid = w_m_valid;

endmodule

// File: tb/tb_fifo_burst_reader_m.sv
// Scoreboard bench for fifo_burst_reader_m with BURST_LEN=4, TIMEOUT=8 and a queue-backed FWFT FIFO.
module tb_fifo_burst_reader_m;

  typedef logic [15:0] word_t;
  typedef struct packed {
    word_t data;
    logic  last;
  } exp_t;

  localparam int unsigned BL = 4;
  localparam int unsigned TO = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic busy;

  fifo_burst_reader_m_if #(.DATA_ITEM_TYPE(word_t)) bus ();

  fifo_burst_reader_m #(
    .DATA_ITEM_TYPE(word_t),
    .BURST_LEN     (BL),
    .TIMEOUT       (TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(flush),
    .busy (busy),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t  sb[$];
  word_t fifo_q[$];

  int total = 0;
  int bad   = 0;

  logic nx_flush  = 1'b0;
  logic nx_rdbusy = 1'b0;
  logic nx_ready  = 1'b1;
  logic rnd_mode  = 1'b0;
  logic pop_pend  = 1'b0;
  int   npops     = 0;
  int   first_pop_cyc = 0;
  int   last_pop_cyc  = 0;
  int   last_beat_cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic expect_beat(input word_t d, input logic l);
    exp_t e;
    e.data = d;
    e.last = l;
    sb.push_back(e);
  endtask

  // One cycle of FIFO model and input drive, all away from the rising edge.
  task automatic tick();
    word_t dummy;
    @(negedge clk);
    if (pop_pend) dummy = fifo_q.pop_front();
    flush           = nx_flush;
    bus.rd_rst_busy = nx_rdbusy;
    bus.m_ready     = rnd_mode ? ($urandom_range(0, 1) == 1) : nx_ready;
    bus.empty       = (fifo_q.size() == 0);
    bus.head        = bus.empty ? '0 : fifo_q[0];
    #1;
    if (rst_n && (bus.empty || bus.rd_rst_busy)) chk("pop_gate", int'(bus.pop), 0);
    pop_pend = bus.pop && rst_n;
    if (pop_pend) begin
      if (npops == 0) first_pop_cyc = cyc;
      last_pop_cyc = cyc;
      npops++;
    end
  endtask

  task automatic wait_drain(input int bound);
    for (int i = 0; i < bound && sb.size() != 0; i++) tick();
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: actual=%0d pending beats required=0", sb.size());
    end
  endtask

  // Monitor: consumes expected beats and checks output stability under back-pressure.
  logic  prev_stall = 1'b0;
  word_t prev_data  = '0;
  logic  prev_last  = 1'b0;
  always begin : monitor
    exp_t e;
    @(negedge clk);
    #2;
    if (rst_n) begin
      if (prev_stall) begin
        chk("stall_valid", int'(bus.m_valid), 1);
        chk("stall_data", int'(bus.m_data), int'(prev_data));
        chk("stall_last", int'(bus.m_last), int'(prev_last));
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
      prev_last  = bus.m_last;
      if (bus.m_valid && bus.m_ready) begin
        last_beat_cyc = cyc;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: actual data=%0h required none", bus.m_data);
        end else begin
          e = sb.pop_front();
          chk("beat_data", int'(bus.m_data), int'(e.data));
          chk("beat_last", int'(bus.m_last), int'(e.last));
        end
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: actual=time-out required=finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    bus.head        = '0;
    bus.empty       = 1'b1;
    bus.rd_rst_busy = 1'b0;
    bus.m_ready     = 1'b1;

    repeat (3) tick();
    chk("rst_m_valid", int'(bus.m_valid), 0);
    chk("rst_m_last", int'(bus.m_last), 0);
    chk("rst_m_data", int'(bus.m_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pop", int'(bus.pop), 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Ten words back to back: bursts of 4, tail released by timeout.
    npops = 0;
    for (int i = 0; i < 10; i++) begin
      fifo_q.push_back(word_t'(i));
      expect_beat(word_t'(i), (i == 3) || (i == 7) || (i == 9));
    end
    wait_drain(200);
    chk("p1_pop_count", npops, 10);
    chk("p1_pop_span", last_pop_cyc - first_pop_cyc, 9);
    chk("p1_tail_latency", last_beat_cyc - last_pop_cyc, TO + 2);
    chk("p1_busy_after", int'(busy), 0);

    // Isolated word.
    npops = 0;
    fifo_q.push_back(16'h00A5);
    expect_beat(16'h00A5, 1'b1);
    wait_drain(100);
    chk("p2_pop_count", npops, 1);
    chk("p2_latency", last_beat_cyc - last_pop_cyc, TO + 2);
    chk("p2_busy_after", int'(busy), 0);

    // Flush with nothing held must not create a beat.
    nx_flush = 1'b1;
    tick();
    nx_flush = 1'b0;
    repeat (3) tick();
    chk("flush_idle_busy", int'(busy), 0);

    // Flush while word 2 is held and the FIFO is dry.
    npops = 0;
    fifo_q.push_back(16'h0030);
    fifo_q.push_back(16'h0031);
    fifo_q.push_back(16'h0032);
    expect_beat(16'h0030, 1'b0);
    expect_beat(16'h0031, 1'b0);
    expect_beat(16'h0032, 1'b1);
    for (int i = 0; i < 20 && npops < 3; i++) tick();
    chk("p3_pops_before_flush", npops, 3);
    nx_flush = 1'b1;
    tick();
    nx_flush = 1'b0;
    fifo_q.push_back(16'h0033);
    fifo_q.push_back(16'h0034);
    fifo_q.push_back(16'h0035);
    expect_beat(16'h0033, 1'b0);
    expect_beat(16'h0034, 1'b0);
    expect_beat(16'h0035, 1'b1);
    wait_drain(100);

    // Random back-pressure over 1000 words.
    rnd_mode = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      fifo_q.push_back(word_t'(16'h1000 + i));
      expect_beat(word_t'(16'h1000 + i), (i % 4) == 3);
    end
    wait_drain(20000);
    rnd_mode = 1'b0;
    nx_ready = 1'b1;
    repeat (2) tick();

    // FIFO read side in reset: treated as empty.
    npops = 0;
    fifo_q.push_back(16'h00B0);
    fifo_q.push_back(16'h00B1);
    expect_beat(16'h00B0, 1'b1);
    expect_beat(16'h00B1, 1'b1);
    tick();
    nx_rdbusy = 1'b1;
    repeat (20) tick();
    chk("p5_pops_during_busy", npops, 1);
    chk("p5_released_during_busy", sb.size(), 1);
    nx_rdbusy = 1'b0;
    wait_drain(100);
    chk("p5_pop_count", npops, 2);

    // Reset with one word in the output register and one held.
    npops = 0;
    nx_ready = 1'b0;
    fifo_q.push_back(16'h00C0);
    fifo_q.push_back(16'h00C1);
    fifo_q.push_back(16'h00C2);
    repeat (4) tick();
    chk("p6_pre_valid", int'(bus.m_valid), 1);
    chk("p6_pre_pops", npops, 2);
    chk("p6_pre_busy", int'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("p6_rst_m_valid", int'(bus.m_valid), 0);
    chk("p6_rst_m_last", int'(bus.m_last), 0);
    chk("p6_rst_m_data", int'(bus.m_data), 0);
    chk("p6_rst_busy", int'(busy), 0);
    fifo_q.delete();
    nx_ready = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      fifo_q.push_back(word_t'(16'h00D0 + i));
      expect_beat(word_t'(16'h00D0 + i), (i == 3) || (i == 4));
    end
    wait_drain(100);
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
